// File: rtl/sprite_line_sequencer_pkg.sv
// Shared types and constants for the motion-sprite line sequencer.
package sprite_line_sequencer_pkg;

    localparam int NUM_SPRITES = 8;
    localparam int LINE_PIXELS = 256;
    localparam int IDX_W       = 3;
    localparam int SPRITE_H    = 8;
    localparam int SPRITE_W    = 8;

    localparam logic [1:0] TRANSPARENT = 2'b00;

    localparam logic [1:0] FIELD_NUM = 2'd0;
    localparam logic [1:0] FIELD_X   = 2'd1;
    localparam logic [1:0] FIELD_Y   = 2'd2;
    localparam logic [1:0] FIELD_EN  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SCAN   = 2'd2,
        ST_RENDER = 2'd3
    } state_t;

    typedef struct packed {
        logic [5:0] num;
        logic [7:0] x;
        logic [7:0] y;
        logic       en;
    } sprite_attr_t;

endpackage

// File: rtl/sprite_attr_table.sv
// Eight-entry sprite attribute register file: field-wise write port, combinational read by index.
module sprite_attr_table
    import sprite_line_sequencer_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [1:0]       field,
    input  logic [7:0]       wdata,
    input  logic [IDX_W-1:0] rd_idx,
    output sprite_attr_t     rd_attr
);

    sprite_attr_t entries [NUM_SPRITES];

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                entries[i] <= '0;
            end
        end else if (we) begin
            case (field)
                FIELD_NUM: entries[wr_idx].num <= wdata[5:0];
                FIELD_X:   entries[wr_idx].x   <= wdata;
                FIELD_Y:   entries[wr_idx].y   <= wdata;
                default:   entries[wr_idx].en  <= wdata[0];
            endcase
        end
    end

    assign rd_attr = entries[rd_idx];

endmodule

// File: rtl/sprite_line_sequencer.sv
// Clears the idle line-RAM half, then scans the attribute table high-to-low and renders each sprite hitting the line.
module sprite_line_sequencer
    import sprite_line_sequencer_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        line_start,
    input  logic [7:0]  line_y,
    input  logic        buf_sel,
    input  logic        attr_we,
    input  logic [2:0]  attr_idx,
    input  logic [1:0]  attr_field,
    input  logic [7:0]  attr_wdata,
    output logic [5:0]  rom_sprite_num,
    output logic [2:0]  rom_row,
    output logic [2:0]  rom_col,
    input  logic [1:0]  rom_pixel,
    output logic        lr_write,
    output logic [10:0] lr_write_addr,
    output logic [1:0]  lr_wr_data,
    output logic        busy,
    output logic        overrun,
    output state_t      dbg_state
);

    state_t           state;
    logic [7:0]       lat_y;
    logic             lat_buf;
    logic [7:0]       clear_x;
    logic [3:0]       rcyc;
    logic [IDX_W-1:0] idx;
    logic [7:0]       snap_x;

    sprite_attr_t cur;
    logic [7:0]   dy;
    logic         hit;
    logic         abort;
    logic         render_wr;
    logic [2:0]   wr_col;
    logic [8:0]   wr_sum;

    sprite_attr_table u_table (
        .clock   (clock),
        .reset   (reset),
        .we      (attr_we),
        .wr_idx  (attr_idx),
        .field   (attr_field),
        .wdata   (attr_wdata),
        .rd_idx  (idx),
        .rd_attr (cur)
    );

    assign dy    = lat_y - cur.y;
    assign hit   = cur.en && (dy < 8'(SPRITE_H));
    assign abort = line_start && (state != ST_IDLE);

    // rom_sprite_num/rom_row double as the render snapshot; they only load on a scan hit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= ST_IDLE;
            lat_y          <= '0;
            lat_buf        <= 1'b0;
            clear_x        <= '0;
            rcyc           <= '0;
            idx            <= '0;
            snap_x         <= '0;
            rom_sprite_num <= '0;
            rom_row        <= '0;
            rom_col        <= '0;
            overrun        <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (line_start) begin
                lat_y   <= line_y;
                lat_buf <= buf_sel;
                clear_x <= '0;
                rcyc    <= '0;
                overrun <= (state != ST_IDLE);
                state   <= ST_CLEAR;
            end else begin
                case (state)
                    ST_IDLE: begin
                    end
                    ST_CLEAR: begin
                        clear_x <= clear_x + 8'd1;
                        if (clear_x == 8'(LINE_PIXELS - 1)) begin
                            idx   <= IDX_W'(NUM_SPRITES - 1);
                            state <= ST_SCAN;
                        end
                    end
                    ST_SCAN: begin
                        if (hit) begin
                            snap_x         <= cur.x;
                            rom_sprite_num <= cur.num;
                            rom_row        <= dy[2:0];
                            rom_col        <= '0;
                            rcyc           <= '0;
                            state          <= ST_RENDER;
                        end else if (idx == '0) begin
                            state <= ST_IDLE;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                    default: begin
                        if (rcyc < 4'(SPRITE_W - 1)) begin
                            rom_col <= rcyc[2:0] + 3'd1;
                        end
                        if (rcyc == 4'(SPRITE_W)) begin
                            rcyc <= '0;
                            if (idx == '0) begin
                                state <= ST_IDLE;
                            end else begin
                                idx   <= idx - 1'b1;
                                state <= ST_SCAN;
                            end
                        end else begin
                            rcyc <= rcyc + 4'd1;
                        end
                    end
                endcase
            end
        end
    end

    // Render writes lag the ROM address by one cycle, so column = rcyc-1 pairs with rom_pixel.
    assign render_wr = (state == ST_RENDER) && (rcyc != 4'd0);
    assign wr_col    = rcyc[2:0] - 3'd1;
    assign wr_sum    = {1'b0, snap_x} + {6'b0, wr_col};

    assign lr_write = reset && !abort &&
                      ((state == ST_CLEAR) ||
                       (render_wr && (rom_pixel != TRANSPARENT) && !wr_sum[8]));
    assign lr_write_addr = {2'b00, lat_buf, render_wr ? wr_sum[7:0] : clear_x};
    assign lr_wr_data    = render_wr ? rom_pixel : TRANSPARENT;
    assign busy          = (state != ST_IDLE);
    assign dbg_state     = state;

endmodule
